// File: rtl/johnson_pkg.sv
// johnson_pkg: shared sizing helpers, direction encodings and phase-to-state mapping
package johnson_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic int jc_n(int width);
    return 2 * width;
  endfunction
  function automatic int jc_pw(int width);
    return $clog2(2 * width);
  endfunction
  // Out-of-range phases map to the all-zero state
  function automatic logic [63:0] johnson_state(int k, int width);
    return (k < 0 || k >= 2 * width) ? '0 :
           (k <= width) ? ((64'd1 << k) - 64'd1) << (width - k) :
           (64'd1 << (2 * width - k)) - 64'd1;
  endfunction
endpackage

// File: rtl/johnson_counter_param_if.sv
// johnson_counter_param_if: control and status bundle of the Johnson counter
interface johnson_counter_param_if import johnson_pkg::*; #(
  parameter int WIDTH = 4,
  localparam int N = jc_n(WIDTH),
  localparam int PW = jc_pw(WIDTH)
);
  logic en;
  logic up_dn;
  logic load;
  logic [PW-1:0] load_phase;
  logic [WIDTH-1:0] q;
  logic [PW-1:0] phase;
  logic [N-1:0] dec;
  logic wrap;
  logic fault;
  modport master(output en, up_dn, load, load_phase, input q, phase, dec, wrap, fault);
  modport slave(input en, up_dn, load, load_phase, output q, phase, dec, wrap, fault);
endinterface

// File: rtl/johnson_decode.sv
// johnson_decode: two-input Johnson phase decode, qualified so illegal codes decode to nothing
module johnson_decode import johnson_pkg::*; #(
  parameter int WIDTH = 4,
  localparam int N = jc_n(WIDTH),
  localparam int PW = jc_pw(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic [N-1:0]     dec,
  output logic             legal
);
  logic [N-1:0] raw;
  logic [WIDTH-2:0] d;
  logic ok;
  for (genvar k = 0; k < N; k++) begin : g_raw
    if (k == 0) begin : g_zero
      assign raw[k] = ~q[WIDTH-1] & ~q[0];
    end else if (k < WIDTH) begin : g_fill
      assign raw[k] = q[WIDTH-k] & ~q[WIDTH-k-1];
    end else if (k == WIDTH) begin : g_full
      assign raw[k] = q[WIDTH-1] & q[0];
    end else begin : g_drain
      assign raw[k] = ~q[N-k] & q[N-k-1];
    end
  end
  // Legal Johnson codes have at most one adjacent-bit transition
  assign d = q[WIDTH-2:0] ^ q[WIDTH-1:1];
  assign ok = (d & (d - (WIDTH-1)'(1))) == '0;
  assign dec = raw & {N{ok}};
  assign legal = |dec;
  always_comb begin
    phase = '0;
    for (int k = 0; k < N; k++) phase = dec[k] ? PW'(k) : phase;
  end
endmodule

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: bidirectional twisted-ring counter with load, self-correction and decode
module johnson_counter_param import johnson_pkg::*; #(
  parameter int WIDTH = 4,
  localparam int N = jc_n(WIDTH),
  localparam int PW = jc_pw(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  johnson_counter_param_if.slave bus
);
  logic [WIDTH-1:0] state, nxt;
  logic legal, wrap_r, fault_r, wrap_nx;
  johnson_decode #(.WIDTH(WIDTH)) u_dec (
    .q(state),
    .phase(bus.phase),
    .dec(bus.dec),
    .legal(legal)
  );
  always_comb begin
    nxt = bus.load ? WIDTH'(johnson_state(int'(bus.load_phase), WIDTH)) :
          !legal ? '0 :
          !bus.en ? state :
          bus.up_dn == DIR_UP ? {~state[0], state[WIDTH-1:1]} : {state[WIDTH-2:0], ~state[WIDTH-1]};
    wrap_nx = !bus.load && legal && bus.en &&
              (bus.up_dn == DIR_DN ? bus.phase == '0 : bus.phase == PW'(N - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      wrap_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state <= nxt;
      wrap_r <= wrap_nx;
      fault_r <= !bus.load && !legal;
    end
  end
  assign bus.q = state;
  assign bus.wrap = wrap_r;
  assign bus.fault = fault_r;
endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param: vector table, corner sequences and random model checks for widths 3, 4, 8
module tb_johnson_counter_param;
  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rsr = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  johnson_counter_param_if #(.WIDTH(4)) b4 ();
  johnson_counter_param_if #(.WIDTH(3)) b3 ();
  johnson_counter_param_if #(.WIDTH(8)) b8 ();
  johnson_counter_param #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4), .bus(b4));
  johnson_counter_param #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rsr), .bus(b3));
  johnson_counter_param #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rsr), .bus(b8));

  typedef struct {
    logic en, up, ld;
    logic [2:0] lp;
    logic [3:0] q;
    int ph;
    logic wr;
  } vec_t;
  vec_t tv [23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Phase k as bits: first k fill from the MSB, then drain from the MSB
  function automatic logic [63:0] ref_q(int k, int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) r[i] = (k <= w) ? (i >= w - k) : (i < 2 * w - k);
    return r;
  endfunction

  int p3, p8, n;
  logic [63:0] pv3, pv8, one;
  logic e3, u3, e8, u8, w3, w8;

  initial begin
    tv = '{
      '{1,1,0,0, 8,1,0}, '{1,1,0,0,12,2,0}, '{1,1,0,0,14,3,0}, '{1,1,0,0,15,4,0},
      '{1,1,0,0, 7,5,0}, '{1,1,0,0, 3,6,0}, '{1,1,0,0, 1,7,0}, '{1,1,0,0, 0,0,1},
      '{1,1,0,0, 8,1,0}, '{1,0,0,0, 0,0,0}, '{1,0,0,0, 1,7,1}, '{1,0,0,0, 3,6,0},
      '{1,0,0,0, 7,5,0}, '{1,1,0,0, 3,6,0}, '{1,1,0,0, 1,7,0}, '{1,1,0,0, 0,0,1},
      '{1,0,0,0, 1,7,1}, '{0,1,0,0, 1,7,0}, '{1,1,1,5, 7,5,0}, '{1,0,1,7, 1,7,0},
      '{1,1,1,0, 0,0,0}, '{0,0,1,4,15,4,0}, '{1,0,0,0,14,3,0}
    };
    {b4.en, b4.up_dn, b4.load, b4.load_phase} = '0;
    {b3.en, b3.up_dn, b3.load, b3.load_phase} = '0;
    {b8.en, b8.up_dn, b8.load, b8.load_phase} = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", 64'(b4.q), 0);
    chk("rst_dec", 64'(b4.dec), 1);
    chk("rst_wrap", 64'(b4.wrap), 0);
    chk("rst_fault", 64'(b4.fault), 0);
    rst4 = 1'b1;
    for (int i = 0; i < 23; i++) begin
      {b4.en, b4.up_dn, b4.load, b4.load_phase} = {tv[i].en, tv[i].up, tv[i].ld, tv[i].lp};
      @(negedge clk);
      one = 64'd1 << tv[i].ph;
      chk($sformatf("tv%0d_q", i), 64'(b4.q), 64'(tv[i].q));
      chk($sformatf("tv%0d_phase", i), 64'(b4.phase), 64'(tv[i].ph));
      chk($sformatf("tv%0d_dec", i), 64'(b4.dec), one);
      chk($sformatf("tv%0d_wrap", i), 64'(b4.wrap), 64'(tv[i].wr));
      chk($sformatf("tv%0d_fault", i), 64'(b4.fault), 0);
    end
    // Illegal code injected through the register, corrected on the next edge
    {b4.en, b4.load} = 2'b00;
    force dut4.state = 4'b0101;
    #1;
    chk("ill_phase", 64'(b4.phase), 0);
    chk("ill_dec", 64'(b4.dec), 0);
    release dut4.state;
    @(negedge clk);
    chk("fix_q", 64'(b4.q), 0);
    chk("fix_fault", 64'(b4.fault), 1);
    chk("fix_dec", 64'(b4.dec), 1);
    b4.en = 1'b1;
    @(negedge clk);
    chk("fix_fault_clr", 64'(b4.fault), 0);
    // Asynchronous reset between edges at q=14
    {b4.load, b4.load_phase} = {1'b1, 3'd3};
    @(negedge clk);
    chk("pre_rst_q", 64'(b4.q), 14);
    {b4.load, b4.en, b4.up_dn} = 3'b011;
    #2 rst4 = 1'b0;
    #1;
    chk("arst_q", 64'(b4.q), 0);
    chk("arst_dec", 64'(b4.dec), 1);
    chk("arst_wrap", 64'(b4.wrap), 0);
    chk("arst_fault", 64'(b4.fault), 0);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    chk("post_rst_q", 64'(b4.q), 8);
    // Random stepping of widths 3 and 8 against the phase model
    rsr = 1'b1;
    p3 = 0;
    p8 = 0;
    for (int c = 0; c < 64; c++) begin
      e3 = 1'($urandom_range(0, 1)); u3 = 1'($urandom_range(0, 1));
      e8 = 1'($urandom_range(0, 3) != 0); u8 = 1'($urandom_range(0, 1));
      {b3.en, b3.up_dn} = {e3, u3};
      {b8.en, b8.up_dn} = {e8, u8};
      pv3 = 64'(b3.q);
      pv8 = 64'(b8.q);
      @(negedge clk);
      w3 = e3 && (u3 ? p3 == 5 : p3 == 0);
      w8 = e8 && (u8 ? p8 == 15 : p8 == 0);
      if (e3) p3 = u3 ? (p3 + 1) % 6 : (p3 + 5) % 6;
      if (e8) p8 = u8 ? (p8 + 1) % 16 : (p8 + 15) % 16;
      chk($sformatf("r%0d_q3", c), 64'(b3.q), ref_q(p3, 3));
      chk($sformatf("r%0d_ph3", c), 64'(b3.phase), 64'(p3));
      chk($sformatf("r%0d_wr3", c), 64'(b3.wrap), 64'(w3));
      chk($sformatf("r%0d_f3", c), 64'(b3.fault), 0);
      chk($sformatf("r%0d_q8", c), 64'(b8.q), ref_q(p8, 8));
      chk($sformatf("r%0d_ph8", c), 64'(b8.phase), 64'(p8));
      chk($sformatf("r%0d_wr8", c), 64'(b8.wrap), 64'(w8));
      chk($sformatf("r%0d_f8", c), 64'(b8.fault), 0);
      if (e3) begin
        n = $countones(64'(b3.q) ^ pv3);
        chk($sformatf("r%0d_onebit3", c), 64'(n), 1);
      end
      if (e8) begin
        n = $countones(64'(b8.q) ^ pv8);
        chk($sformatf("r%0d_onebit8", c), 64'(n), 1);
      end
    end
    // Width 3 loads, including a phase index beyond the sequence
    {b3.load, b3.en, b3.up_dn, b3.load_phase} = {3'b111, 3'd4};
    @(negedge clk);
    chk("w3_load4_q", 64'(b3.q), 3);
    chk("w3_load4_wrap", 64'(b3.wrap), 0);
    b3.load_phase = 3'd7;
    @(negedge clk);
    chk("w3_load7_q", 64'(b3.q), 0);
    chk("w3_load7_wrap", 64'(b3.wrap), 0);
    chk("w3_load7_fault", 64'(b3.fault), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
